// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU / LSU / MDU results per cycle, aligns and
// extends load data, and registers a single write into the integer register file.
module wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_rd,
    input  logic [2:0]            lsu_funct3,
    input  logic [1:0]            lsu_offset,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [4:0]            mdu_rd,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  wr_en,
    output logic [4:0]            addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic [31:0]           retire_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]         starve_q, starve_d;
    logic                  promote;
    logic                  wr_en_q, wr_en_d;
    logic [4:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           retire_q, retire_d;

    logic                  lsu_acc, mdu_acc, any_acc;
    logic [4:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    // Handshake: a source's result transfers on a rising edge where its valid and
    // ready are both high; producers hold valid/rd/data stable until then. The ALU
    // has no ready and is accepted whenever valid.
    assign promote   = (starve_q == LIMIT);
    assign lsu_ready = !alu_valid && !(promote && mdu_valid);
    assign mdu_ready = !alu_valid && (promote || !lsu_valid);
    assign lsu_acc   = lsu_valid && lsu_ready;
    assign mdu_acc   = mdu_valid && mdu_ready;
    assign any_acc   = alu_valid || lsu_acc || mdu_acc;

    always_comb begin
        ld_byte = lsu_rdata[7:0];
        case (lsu_offset)
            2'd1:    ld_byte = lsu_rdata[15:8];
            2'd2:    ld_byte = lsu_rdata[23:16];
            2'd3:    ld_byte = lsu_rdata[31:24];
            default: ld_byte = lsu_rdata[7:0];
        endcase
        ld_half = lsu_offset[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        case (lsu_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = lsu_rdata;
        endcase
    end

    always_comb begin
        sel_rd   = mdu_rd;
        sel_data = mdu_data;
        if (alu_valid) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (lsu_acc) begin
            sel_rd   = lsu_rd;
            sel_data = load_data;
        end

        // x0 writes still consume the source but never reach the register file.
        wr_en_d  = any_acc && (sel_rd != 5'd0);
        addr_d   = addr_q;
        data_d   = data_q;
        retire_d = retire_q;
        if (wr_en_d) begin
            addr_d   = sel_rd;
            data_d   = sel_data;
            retire_d = retire_q + 32'd1;
        end

        starve_d = starve_q;
        if (!mdu_valid || mdu_acc) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            retire_q <= '0;
        end else begin
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            retire_q <= retire_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign addr_wr    = addr_q;
    assign data_wr    = data_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed cases plus randomized traffic
// compared every cycle against a priority-list reference model.
module tb_wb_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, mdu_valid;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd;
    logic [31:0] alu_data, lsu_rdata, mdu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_offset;
    logic        lsu_ready, mdu_ready, wr_en;
    logic [4:0]  addr_wr;
    logic [31:0] data_wr, retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_starve;
    logic        m_wr_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_retire;
    logic        m_lsu_acc, m_mdu_acc;

    wb_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset), .lsu_rdata(lsu_rdata),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic exp_lsu_ready();
        return !alu_valid && !((m_starve == LIMIT) && mdu_valid);
    endfunction

    function automatic logic exp_mdu_ready();
        return !alu_valid && ((m_starve == LIMIT) || !lsu_valid);
    endfunction

    task automatic m_reset();
        m_starve  = 0;
        m_wr_en   = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_retire  = '0;
        m_lsu_acc = 1'b0;
        m_mdu_acc = 1'b0;
    endtask

    // Winner is the first valid source in the current priority list.
    task automatic model_step();
        int          winner;  // 0 none, 1 alu, 2 lsu, 3 mdu
        int          order[3];
        logic        v[4];
        logic [4:0]  rd;
        logic [31:0] d;
        if (!rst_n) begin
            m_reset();
            return;
        end
        v[0] = 1'b0; v[1] = alu_valid; v[2] = lsu_valid; v[3] = mdu_valid;
        order[0] = 1;
        order[1] = (m_starve == LIMIT) ? 3 : 2;
        order[2] = (m_starve == LIMIT) ? 2 : 3;
        winner = 0;
        for (int i = 2; i >= 0; i--) if (v[order[i]]) winner = order[i];
        m_lsu_acc = (winner == 2);
        m_mdu_acc = (winner == 3);
        rd = 5'd0; d = '0;
        if (winner == 1) begin rd = alu_rd; d = alu_data; end
        if (winner == 2) begin rd = lsu_rd; d = m_load(lsu_funct3, int'(lsu_offset), lsu_rdata); end
        if (winner == 3) begin rd = mdu_rd; d = mdu_data; end
        if (mdu_valid && winner != 3) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else m_starve = 0;
        m_wr_en = (winner != 0) && (rd != 5'd0);
        if (m_wr_en) begin
            m_addr   = rd;
            m_data   = d;
            m_retire = m_retire + 32'd1;
        end
    endtask

    // compare process: runs on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_lsu_ready()});
        check("mdu_ready", {31'd0, mdu_ready}, {31'd0, exp_mdu_ready()});
        check("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
        check("addr_wr", {27'd0, addr_wr}, {27'd0, m_addr});
        check("data_wr", data_wr, m_data);
        check("retire_cnt", retire_cnt, m_retire);
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_case(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp, input string name);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = f3; lsu_offset = off; lsu_rdata = 32'h80FF_7F01;
        step();
        lsu_valid = 1'b0;
        check(name, data_wr, exp);
    endtask

    task automatic random_phase(input int cycles, input int alu_pct, input int lsu_pct, input int mdu_pct);
        for (int c = 0; c < cycles; c++) begin
            alu_valid = ($urandom_range(0, 99) < alu_pct);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            if (!lsu_valid || m_lsu_acc) begin
                lsu_valid  = ($urandom_range(0, 99) < lsu_pct);
                lsu_rd     = 5'($urandom_range(0, 31));
                lsu_funct3 = 3'($urandom_range(0, 7));
                lsu_offset = 2'($urandom_range(0, 3));
                lsu_rdata  = $urandom;
            end
            if (!mdu_valid || m_mdu_acc) begin
                mdu_valid = ($urandom_range(0, 99) < mdu_pct);
                mdu_rd    = 5'($urandom_range(0, 31));
                mdu_data  = $urandom;
            end
            step();
        end
    endtask

    initial begin
        int          first_grant;
        logic [31:0] saved;
        m_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_funct3 = '0; lsu_offset = '0; lsu_rdata = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
        step();
        step();
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_retire", retire_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        // single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        step();
        alu_valid = 1'b0;
        check("alu_wr_en", {31'd0, wr_en}, 32'd1);
        check("alu_addr", {27'd0, addr_wr}, 32'd5);
        check("alu_data", data_wr, 32'h1234_5678);
        check("alu_retire", retire_cnt, 32'd1);
        step();
        check("alu_pulse_end", {31'd0, wr_en}, 32'd0);

        // load extraction
        load_case(3'b000, 2'd2, 32'hFFFF_FFFF, "lb_off2");
        load_case(3'b100, 2'd3, 32'h0000_0080, "lbu_off3");
        load_case(3'b001, 2'd2, 32'hFFFF_80FF, "lh_off2");
        load_case(3'b101, 2'd0, 32'h0000_7F01, "lhu_off0");
        load_case(3'b010, 2'd3, 32'h80FF_7F01, "lw_off3");
        load_case(3'b111, 2'd1, 32'h80FF_7F01, "undef_f3_as_lw");
        check("load_retire", retire_cnt, 32'd7);

        // all three valid: ALU wins three times, then LSU, then MDU
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'b010; lsu_rdata = 32'hAAAA_0000;
        mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'(i + 100);
            #1;
            check("all_valid_lsu_ready", {31'd0, lsu_ready}, 32'd0);
            check("all_valid_mdu_ready", {31'd0, mdu_ready}, 32'd0);
            step();
            check("all_valid_alu_addr", {27'd0, addr_wr}, 32'(i + 1));
        end
        alu_valid = 1'b0;
        #1;
        check("alu_drop_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("alu_drop_mdu_ready", {31'd0, mdu_ready}, 32'd0);
        step();
        lsu_valid = 1'b0;
        check("lsu_after_alu", {27'd0, addr_wr}, 32'd9);
        #1;
        check("mdu_next_ready", {31'd0, mdu_ready}, 32'd1);
        step();
        mdu_valid = 1'b0;
        check("mdu_after_lsu_addr", {27'd0, addr_wr}, 32'd10);
        check("mdu_after_lsu_data", data_wr, 32'h0000_BEEF);
        step();

        // starvation guard
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_funct3 = 3'b010; lsu_rdata = $urandom;
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h5555_AAAA;
        first_grant = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            #1;
            if (first_grant != 0 && cyc == first_grant + 1)
                check("starve_cleared", {31'd0, mdu_ready}, 32'd0);
            if (mdu_ready && first_grant == 0) begin
                first_grant = cyc;
                check("starve_lsu_blocked", {31'd0, lsu_ready}, 32'd0);
            end
            step();
            if (m_lsu_acc) lsu_rdata = $urandom;
        end
        check("starve_grant_cycle", 32'(first_grant), 32'd9);
        lsu_valid = 1'b0; mdu_valid = 1'b0;
        step();

        // x0 destinations
        saved = retire_cnt;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        step();
        alu_valid = 1'b0;
        check("alu_x0_wr_en", {31'd0, wr_en}, 32'd0);
        check("alu_x0_retire", retire_cnt, saved);
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h0BAD_F00D;
        #1;
        check("mdu_x0_ready", {31'd0, mdu_ready}, 32'd1);
        step();
        mdu_valid = 1'b0;
        check("mdu_x0_wr_en", {31'd0, wr_en}, 32'd0);
        check("mdu_x0_retire", retire_cnt, saved);

        // reset right after an accepted load
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_funct3 = 3'b010; lsu_rdata = 32'hCAFE_0001;
        step();
        lsu_valid = 1'b0;
        check("pre_reset_wr_en", {31'd0, wr_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async_reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("async_reset_retire", retire_cnt, 32'd0);
        check("async_reset_addr", {27'd0, addr_wr}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_retire", retire_cnt, 32'd0);
        check("post_reset_wr_en", {31'd0, wr_en}, 32'd0);

        // randomized traffic across several load mixes
        random_phase(600, 0, 70, 80);
        random_phase(600, 10, 80, 90);
        random_phase(600, 40, 60, 60);
        random_phase(600, 85, 50, 50);
        alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute-side result producers (ALU, load/store unit, multiply/divide unit) and the integer register file write port. Each cycle it selects at most one result, performs load-data alignment and extension, and drives a registered `wr_en`/`addr_wr`/`data_wr` triple into the register file. It also keeps a starvation guard for the multiply/divide unit and a retired-write counter.

## Interface
- `DATA_WIDTH`, 32: datapath width, fixed at 32 for RV32I load extension.
- `STARVE_LIMIT`, 8: consecutive lost MDU arbitrations before the MDU is promoted above the LSU.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present; no back-pressure, always accepted.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `lsu_valid`  in  1  load result present.
- `lsu_ready`  out  1  load result accepted this cycle.
- `lsu_rd`  in  5  load destination.
- `lsu_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `lsu_offset`  in  2  byte address bits [1:0].
- `lsu_rdata`  in  DATA_WIDTH  raw aligned memory word.
- `mdu_valid`  in  1  MDU result present.
- `mdu_ready`  out  1  MDU result accepted this cycle.
- `mdu_rd`  in  5  MDU destination.
- `mdu_data`  in  DATA_WIDTH  MDU result.
- `wr_en`  out  1  register-file write enable (registered).
- `addr_wr`  out  5  register-file write address (registered).
- `data_wr`  out  DATA_WIDTH  register-file write data (registered).
- `retire_cnt`  out  32  count of register-file writes performed.

## Operation
- Priority: ALU > LSU > MDU, except that in promoted mode the order is ALU > MDU > LSU.
- `lsu_ready` and `mdu_ready` are combinational from the valids and the promotion flag. `lsu_ready = !alu_valid && !(promote && mdu_valid)`. `mdu_ready = !alu_valid && (promote || !lsu_valid)`.
- A handshake completes when `valid && ready` at a rising edge. Producers hold `valid`, `rd` and data stable until accepted.
- Load extraction: byte = `lsu_rdata[8*offset +: 8]`; half = `lsu_rdata[16*offset[1] +: 16]`.
  - LB/LH sign-extend to DATA_WIDTH; LBU/LHU zero-extend; LW passes the word through.
  - `lsu_offset[0]` is ignored for halves and all offset bits are ignored for LW; alignment faults are handled upstream.
  - Undefined funct3 values (011, 110, 111) behave as LW.
- x0 destination: the source is still accepted (ready asserted normally), but `wr_en` stays 0 and `retire_cnt` does not increment.
- Starvation counter `starve_cnt` (width ceil(log2(STARVE_LIMIT+1))):
  - increments when `mdu_valid && !mdu_ready`;
  - clears when the MDU is accepted or `mdu_valid` is 0;
  - saturates at STARVE_LIMIT.
- `promote = (starve_cnt == STARVE_LIMIT)`. It stays asserted until the next MDU acceptance.
- The ALU can starve both other sources indefinitely. This is by design: the issue stage guarantees ALU bubbles.

## Timing
- Latency is one cycle: an accepted result appears on `wr_en/addr_wr/data_wr` for exactly one cycle after the acceptance edge.
- `wr_en` is 0 in any cycle following an edge with no accepted non-x0 result. `addr_wr`/`data_wr` hold their last value when `wr_en` is 0.
- Back-to-back results sustain one write per cycle with no bubble.
- `retire_cnt` increments on the same edge that asserts `wr_en` and wraps 0xFFFFFFFF -> 0.
- Reset (asynchronous, any cycle, including mid-handshake):
  - `wr_en`=0, `addr_wr`=0, `data_wr`=0, `retire_cnt`=0, `starve_cnt`=0, `promote`=0.
  - An in-flight registered write is dropped.
  - During reset, the ready outputs follow their combinational equations with `promote`=0.
- Simultaneous valids on all three sources: only one is accepted; losers see ready=0 and retry the next cycle.

## Test plan
- ALU `alu_rd`=5, `alu_data`=0x1234_5678 -> next cycle `wr_en`=1, `addr_wr`=5, `data_wr`=0x1234_5678, `retire_cnt`=1.
- LSU `lsu_rdata`=0x80FF_7F01, LB at offset 2 -> `data_wr`=0xFFFF_FFFF; LBU offset 3 -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF; LHU offset 0 -> 0x0000_7F01.
- ALU, LSU and MDU all valid for 3 cycles -> `lsu_ready`=0 and `mdu_ready`=0 throughout, with three ALU writes. Then the ALU drops -> LSU is accepted, then MDU on the following cycle.
- LSU valid continuously and MDU valid continuously, STARVE_LIMIT=8 -> `mdu_ready` asserts on the 9th cycle, `lsu_ready`=0 that cycle, and the counter clears afterward.
- ALU write with `alu_rd`=0 -> no `wr_en` pulse and `retire_cnt` unchanged; an MDU result to x0 -> `mdu_ready`=1 and no write.
- `rst_n` pulsed low on the cycle after an accepted LSU result -> `wr_en` is forced to 0 immediately and the counters read 0 after reset release.
